// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Purpose  : Shared constants for the UART transmit arbiter: byte width,
//             byte type and the arbiter FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Arbiter FSM encodings, kept as plain constants so legacy code can share them.
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_SEND  = 2'd1;
    localparam logic [1:0] ARB_START = 2'd2;
    localparam logic [1:0] ARB_DONE  = 2'd3;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Returns the first requester at
//             or after the pointer, wrapping to index 0 when nothing at or
//             above the pointer is requesting.
//  Ports    : req_i   - request vector
//             ptr_i   - highest-priority index
//             grant_o - one-hot winner (0 when no request)
//             idx_o   - binary index of the winner
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);

    logic w_found;

    // Two passes: first over requests masked to index >= pointer, then over
    // all requests, which provides the wrap-around.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req_i[i] && (PW'(i) >= ptr_i)) begin
                w_found    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req_i[i]) begin
                w_found    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = PW'(i);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one uart_tx among NUM_REQ byte-stream requesters with
//             packet-granular round-robin arbitration and a lock timeout.
//  Ports    : clk, resetn (async, active low)
//             req_valid_i/req_data_i/req_last_i - per-requester byte stream
//             req_ready_o - transfer accept, granted requester only
//             tx_e_o/tx_d_o - start pulse and byte to uart_tx
//             tx_busy_i     - uart_tx busy
//             grant_o       - one-hot current owner, 0 when idle
//             timeout_o     - pulse when a stalled owner is evicted
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_e_o,
    output logic [BYTE_W-1:0]         tx_d_o,
    input  logic                      tx_busy_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      timeout_o
);

    localparam int              PW         = $clog2(NUM_REQ);
    localparam int              CW         = $clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0]   C_CNT_MAX  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0]   C_LAST_IDX = PW'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      gidx_q,  gidx_d;
    logic [PW-1:0]      ptr_q,   ptr_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    byte_t              txd_q,   txd_d;
    logic               last_q,  last_d;
    logic               txe_q,   txe_d;
    logic               tout_q,  tout_d;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [PW-1:0]      w_arb_idx;
    logic               w_sel_valid;
    logic               w_sel_last;
    byte_t              w_sel_data;
    logic               w_xfer;
    logic [PW-1:0]      w_next_ptr;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (w_arb_grant),
        .idx_o   (w_arb_idx)
    );

    // Select the owner's valid/last/data by binary index.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                w_sel_valid = req_valid_i[i];
                w_sel_last  = req_last_i[i];
                w_sel_data  = req_data_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_xfer     = (state_q == ARB_SEND) && w_sel_valid && !tx_busy_i;
    assign w_next_ptr = (gidx_q == C_LAST_IDX) ? '0 : gidx_q + 1'b1;

    // grant_q is one-hot, so masking with it exposes ready on the owner only.
    assign req_ready_o = ((state_q == ARB_SEND) && !tx_busy_i) ? (grant_q & req_valid_i) : '0;
    assign tx_e_o      = txe_q;
    assign tx_d_o      = txd_q;
    assign grant_o     = grant_q;
    assign timeout_o   = tout_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        last_d  = last_q;
        txe_d   = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid_i) begin
                    grant_d = w_arb_grant;
                    gidx_d  = w_arb_idx;
                    cnt_d   = '0;
                    state_d = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (w_xfer) begin
                    txd_d   = w_sel_data;
                    last_d  = w_sel_last;
                    cnt_d   = '0;
                    txe_d   = 1'b1;  // registered, so high for the first START cycle only
                    state_d = ARB_START;
                end else if (cnt_q == C_CNT_MAX) begin
                    tout_d  = 1'b1;
                    ptr_d   = w_next_ptr;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ARB_START: begin
                if (tx_busy_i) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                if (!tx_busy_i) begin
                    cnt_d = '0;
                    if (last_q) begin
                        ptr_d   = w_next_ptr;
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_SEND;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            last_q  <= 1'b0;
            txe_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            last_q  <= last_d;
            txe_q   <= txe_d;
            tout_q  <= tout_d;
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//             LOCK_TIMEOUT=16) with a uart_tx busy model, a vector table of
//             arbitration cases and hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int LT       = 16;
    localparam int BUSY_LEN = 20;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NR-1:0] req_valid_i;
    logic [8*NR-1:0] req_data_i;
    logic [NR-1:0] req_last_i;
    logic [NR-1:0] req_ready_o;
    logic          tx_e_o;
    logic [7:0]    tx_d_o;
    logic          tx_busy_i;
    logic [NR-1:0] grant_o;
    logic          timeout_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_e_o      (tx_e_o),
        .tx_d_o      (tx_d_o),
        .tx_busy_i   (tx_busy_i),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    // uart_tx model: busy rises the cycle after e_i and lasts BUSY_LEN cycles.
    logic force_busy;
    int   busy_cnt;
    assign tx_busy_i = force_busy | (busy_cnt != 0);
    always @(posedge clk or negedge resetn) begin
        if (!resetn)         busy_cnt <= 0;
        else if (tx_e_o)     busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester byte queues: {last, data}
    logic [8:0] rbuf [NR][16];
    int         rhead [NR];
    int         rtail [NR];
    logic [7:0] exp_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_reqs();
        for (int n = 0; n < NR; n++) begin
            if (rhead[n] < rtail[n]) begin
                req_valid_i[n]        = 1'b1;
                req_data_i[n*8 +: 8]  = rbuf[n][rhead[n]][7:0];
                req_last_i[n]         = rbuf[n][rhead[n]][8];
            end else begin
                req_valid_i[n]        = 1'b0;
                req_data_i[n*8 +: 8]  = 8'hEE;
                req_last_i[n]         = 1'b0;
            end
        end
    endtask

    task automatic push_req(input int n, input logic [7:0] d, input logic last);
        rbuf[n][rtail[n]] = {last, d};
        rtail[n]++;
    endtask

    task automatic clear_reqs();
        for (int n = 0; n < NR; n++) begin
            rhead[n] = 0;
            rtail[n] = 0;
        end
        drive_reqs();
    endtask

    function automatic int pending();
        int s = 0;
        for (int n = 0; n < NR; n++) s += rtail[n] - rhead[n];
        return s;
    endfunction

    // One clock: account handshakes seen before the edge, then present next bytes.
    task automatic tick();
        @(posedge clk);
        for (int n = 0; n < NR; n++)
            if (req_valid_i[n] && req_ready_o[n]) rhead[n]++;
        #1;
        drive_reqs();
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || grant_o != 0 || tx_busy_i || pending() != 0) && k < 3000) begin
            tick();
            k++;
        end
        check({name, "_drain"}, 32'(k < 3000), 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    logic          prev_e = 1'b0;
    logic [NR-1:0] prev_g = '0;
    logic [NR-1:0] g_at_to = '0;
    logic [NR-1:0] gseq [16];
    int            gn = 0;
    int            to_cnt = 0;
    int            to_cyc = 0;
    int            e_cyc = 0;
    int            bad_int = 0;
    logic [7:0]    eb;

    always @(negedge clk) begin
        if (resetn) begin
            if (tx_e_o) begin
                e_cyc = cyc;
                check("tx_e_single_pulse", 32'(prev_e), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_unexpected: actual byte %0h required none (cycle %0d)", tx_d_o, cyc);
                end else begin
                    eb = exp_q.pop_front();
                    check("tx_d", 32'(tx_d_o), 32'(eb));
                end
            end
            if (req_ready_o != 0) check("ready_only_owner", 32'(req_ready_o & ~grant_o), 32'd0);
            if (req_ready_o[2] && grant_o[0]) bad_int++;
            if (timeout_o) begin
                to_cnt++;
                to_cyc  = cyc;
                g_at_to = grant_o;
            end
            if (grant_o != 0 && prev_g == 0 && gn < 16) begin
                gseq[gn] = grant_o;
                gn++;
            end
        end
        prev_e = tx_e_o;
        prev_g = grant_o;
    end

    // Arbitration vectors: each requester in mask sends one 1-byte packet.
    // ord lists the expected service order, 2 bits per slot, first slot at [1:0].
    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] exp_grant;
        logic [2:0] n_ord;
        logic [7:0] ord;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] vdata(input int k, input int n);
        return (k == 0) ? 8'hA5 : 8'(k * 16 + n);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int t0;
        int viol;
        // pointer trace: 0 ->1 ->1 ->2 ->1 ->1 ->1 ->0 ->3
        vecs[0] = '{mask: 4'b0001, exp_grant: 4'b0001, n_ord: 3'd1, ord: 8'h00};
        vecs[1] = '{mask: 4'b0101, exp_grant: 4'b0100, n_ord: 3'd2, ord: 8'h02};
        vecs[2] = '{mask: 4'b0010, exp_grant: 4'b0010, n_ord: 3'd1, ord: 8'h01};
        vecs[3] = '{mask: 4'b1001, exp_grant: 4'b1000, n_ord: 3'd2, ord: 8'h03};
        vecs[4] = '{mask: 4'b1111, exp_grant: 4'b0010, n_ord: 3'd4, ord: 8'h39};
        vecs[5] = '{mask: 4'b0001, exp_grant: 4'b0001, n_ord: 3'd1, ord: 8'h00};
        vecs[6] = '{mask: 4'b1100, exp_grant: 4'b0100, n_ord: 3'd2, ord: 8'h0E};
        vecs[7] = '{mask: 4'b0110, exp_grant: 4'b0010, n_ord: 3'd2, ord: 8'h09};

        resetn      = 1'b0;
        force_busy  = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({grant_o, req_ready_o, tx_e_o, timeout_o, tx_d_o}), 32'd0);
        resetn = 1'b1;
        tick();
        tick();

        // ---- table-driven arbitration and latency ----
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < NR; n++)
                if (vecs[k].mask[n]) push_req(n, vdata(k, n), 1'b1);
            for (int i = 0; i < int'(vecs[k].n_ord); i++)
                exp_q.push_back(vdata(k, int'(vecs[k].ord[2*i +: 2])));
            drive_reqs();
            @(negedge clk);
            check("idle_grant", 32'(grant_o), 32'd0);
            tick();
            @(negedge clk);
            check("grant_latency", 32'(grant_o), 32'(vecs[k].exp_grant));
            check("ready_latency", 32'(req_ready_o), 32'(vecs[k].exp_grant));
            tick();
            @(negedge clk);
            check("tx_e_latency", 32'(tx_e_o), 32'd1);
            drain("vec");
        end

        // ---- multi-byte packets never interleave (pointer is 3 here) ----
        bad_int = 0;
        push_req(0, 8'h11, 1'b0); push_req(0, 8'h22, 1'b0); push_req(0, 8'h33, 1'b1);
        push_req(2, 8'h44, 1'b0); push_req(2, 8'h55, 1'b1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        drive_reqs();
        drain("packets");
        check("no_ready2_while_grant0", 32'(bad_int), 32'd0);

        // ---- all four continuously requesting: strict rotation from 0 ----
        do_reset();
        gn = 0;
        for (int r = 0; r < 2; r++)
            for (int n = 0; n < NR; n++) begin
                push_req(n, 8'(8'h30 + r * 16 + n), 1'b1);
                exp_q.push_back(8'(8'h30 + r * 16 + n));
            end
        drive_reqs();
        drain("rotation");
        check("rotation_grant_count", 32'(gn), 32'd8);
        for (int i = 0; i < 6; i++)
            check("rotation_grant_seq", 32'(gseq[i]), 32'(4'b0001 << (i % 4)));

        // ---- stalled packet evicted by the lock timeout (pointer is 0) ----
        gn = 0;
        t0 = to_cnt;
        push_req(1, 8'h10, 1'b0);
        push_req(3, 8'h33, 1'b1);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h33);
        drive_reqs();
        k0 = 0;
        while (to_cnt == t0 && k0 < 200) begin
            tick();
            k0++;
        end
        check("timeout_seen", 32'(to_cnt != t0), 32'd1);
        // tx_e at c; busy c+1..c+20; DONE exits at c+21; SEND c+22..c+37; timeout_o at c+38
        check("timeout_delay", 32'(to_cyc - e_cyc), 32'd38);
        check("timeout_grant_released", 32'(g_at_to), 32'd0);
        drain("timeout");
        check("timeout_single_pulse", 32'(to_cnt - t0), 32'd1);
        check("timeout_first_owner", 32'(gseq[0]), 32'b0010);
        check("timeout_next_owner", 32'(gseq[1]), 32'b1000);
        push_req(1, 8'h11, 1'b1);
        exp_q.push_back(8'h11);
        drive_reqs();
        drain("resume");
        check("resume_owner", 32'(gseq[2]), 32'b0010);

        // ---- asynchronous reset in the middle of a byte ----
        push_req(2, 8'h7E, 1'b1);
        exp_q.push_back(8'h7E);
        drive_reqs();
        k0 = 0;
        while (!tx_busy_i && k0 < 20) begin
            tick();
            k0++;
        end
        check("busy_seen", 32'(tx_busy_i), 32'd1);
        repeat (3) tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", 32'({grant_o, req_ready_o, tx_e_o, timeout_o, tx_d_o}), 32'd0);
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        gn = 0;
        push_req(2, 8'h02, 1'b1);
        push_req(0, 8'h01, 1'b1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        drive_reqs();
        drain("post_reset");
        check("post_reset_first", 32'(gseq[0]), 32'b0001);
        check("post_reset_second", 32'(gseq[1]), 32'b0100);

        // ---- transmitter held busy: owner granted but never accepted ----
        force_busy = 1'b1;
        push_req(3, 8'h66, 1'b1);
        exp_q.push_back(8'h66);
        drive_reqs();
        tick();
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready_o != 0 || tx_e_o) viol++;
            tick();
        end
        @(negedge clk);
        check("busy_hold_owner", 32'(grant_o), 32'b1000);
        check("busy_hold_no_accept", 32'(viol), 32'd0);
        force_busy = 1'b0;
        tick();
        drain("busy_release");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
